ser9_tx: RTL
============

SER9_TX -- requirements
Module: ser9_tx

Interface
REQ-001 SHALL provide parameter DIV, default 4: clocks per serial bit period; legal range 1..255.
REQ-002 SHALL provide parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-003 SHALL provide port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL provide port in_valid  input  1  upstream word present.
REQ-006 SHALL provide port in_ready  output  1  block able to accept a word.
REQ-007 SHALL provide port in_data  input  9  parallel word, [8:0].
REQ-008 SHALL provide port in_rep  input  4  extra repeats of the word; 0 gives one frame, 15 gives sixteen frames.
REQ-009 SHALL provide port sout  output  1  serial line, registered, idle high.
REQ-010 SHALL provide port busy  output  1  high from word acceptance until the last stop bit completes.
REQ-011 SHALL provide port done  output  1  one-cycle pulse when the last frame of a word completes.

Function
REQ-012 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-013 SHALL perform a transfer on a rising edge where in_valid and in_ready are both 1; in_ready SHALL equal (state == IDLE).
REQ-014 On transfer, SHALL capture in_data into a hold register and a shift register, load the repeat counter from in_rep, and enter START.
REQ-015 SHALL register sout, so that sout = 0 from the transfer edge onward.
REQ-016 Frame, each bit held exactly DIV clocks:
- start bit 0;
- in_data[0]..in_data[8], LSB first, via logical right shift by 1;
- even parity bit = XOR of all 9 data bits;
- STOP_BITS stop bits at 1.
REQ-017 Frame length SHALL be (11+STOP_BITS)*DIV clocks.
REQ-018 SHALL use a bit counter of 4 bits; it SHALL wrap only on DATA exit, after 9 bits.
REQ-019 SHALL use a divide counter of $clog2(DIV+1) bits; with DIV=1 it SHALL advance one bit every clock.
REQ-020 At the end of the last stop bit, if the repeat counter is nonzero, SHALL decrement it, reload the shift register from the hold register, and enter START with zero idle gap.
REQ-021 At the end of the last stop bit with the repeat counter at zero, SHALL enter IDLE, pulse done for exactly one cycle, and deassert busy in that same cycle.
REQ-022 A transfer SHALL be legal in the same cycle done is high, giving back-to-back words with no gap.
REQ-023 in_valid and in_data while in_ready is 0 SHALL be ignored; no word SHALL be lost or duplicated.
REQ-024 Changes on in_data or in_rep after the transfer SHALL NOT affect frames in flight.

Reset
REQ-025 While rst_n = 0, SHALL hold sout=1, busy=0, done=0, state=IDLE (in_ready=1), and all counters and registers at 0.
REQ-026 Reset asserted mid-frame SHALL force sout=1 immediately without waiting for a clock edge, and SHALL discard the word and any pending repeats.
REQ-027 Reset deassertion SHALL take effect synchronously on the next rising clk edge.

Structure
REQ-028 Package ser9_pkg SHALL hold:
- the state enum typedef;
- WORD_W = 9;
- FRAME_CORE_BITS = 11.
REQ-029 Sub-module ser9_tick (DIV parameter) SHALL generate the bit-period tick and restart on transfer and on each frame reload.

Verification
REQ-030 Reset: hold rst_n=0 with in_valid=1 -> sout=1, busy=0, done=0, in_ready=1, no transfer.
REQ-031 Single word: DIV=4, in_data=9'h0A5, in_rep=0 -> sout bits 0,1,0,1,0,0,1,0,1,0, parity 0, stop 1, each 4 clocks; done 48 clocks after transfer.
REQ-032 Repeat: in_data=9'h1FF, in_rep=2 -> three contiguous frames with parity 1 and no idle gap; in_ready=0 for 144 clocks; exactly one done.
REQ-033 Back-pressure: second word 9'h003 presented mid-frame -> accepted only on the done cycle; its start bit immediately follows the stop bit of the first word.
REQ-034 Reset mid-frame: rst_n=0 during data bit 4 -> sout=1 with no clock edge; a subsequent 9'h155 transmits a complete, correct frame.
REQ-035 Minimum divide: DIV=1, STOP_BITS=2, in_data=9'h000 -> sout low 11 clocks, high 2 clocks, done on clock 13.

Source files
------------

// File: rtl/ser9_pkg.sv
// Shared types and constants for the 9-bit serial transmitter.
package ser9_pkg;

    localparam int WORD_W          = 9;
    localparam int FRAME_CORE_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/ser9_tick.sv
// Bit-period timer: tick is high on the last clock of each DIV-clock bit slot.
module ser9_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt;

    // With DIV=1 the terminal count is 0, so tick asserts on every running clock.
    assign tick = run && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ser9_tx.sv
// 9-bit serial transmitter: start, 9 data bits LSB first, even parity, 1-2 stop bits,
// with per-word repeat count.
module ser9_tx
    import ser9_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_data,
    input  logic [3:0]  in_rep,
    output logic        sout,
    output logic        busy,
    output logic        done
);

    state_t              state;
    logic [WORD_W-1:0]   hold_reg;
    logic [WORD_W-1:0]   shift_reg;
    logic [3:0]          rep_cnt;
    logic [3:0]          bit_cnt;
    logic                stop_cnt;
    logic                tick;
    logic                take;
    logic                last_stop;
    logic                reload;

    assign in_ready  = (state == IDLE);
    assign take      = in_valid && in_ready;
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
    assign reload    = (state == STOP) && tick && last_stop && (rep_cnt != '0);

    ser9_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state != IDLE),
        .restart (take || reload),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_reg  <= '0;
            shift_reg <= '0;
            rep_cnt   <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            sout      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold_reg  <= in_data;
                        shift_reg <= in_data;
                        rep_cnt   <= in_rep;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        sout      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        sout      <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == 4'(WORD_W - 1)) begin
                            bit_cnt <= '0;
                            sout    <= ^hold_reg;
                            state   <= PARITY;
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            sout      <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        sout     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!last_stop) begin
                            stop_cnt <= 1'b1;
                        end else if (rep_cnt != '0) begin
                            // Repeat: reload from the held copy and start the next frame with no gap.
                            rep_cnt   <= rep_cnt - 4'd1;
                            shift_reg <= hold_reg;
                            stop_cnt  <= 1'b0;
                            sout      <= 1'b0;
                            state     <= START;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
